// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants, unit ids and the broadcast payload type.
// The decoder and ROB also use these definitions.
package cdb_arbiter_pkg;

  localparam int unsigned N_UNITS = 4;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PTR_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  localparam logic [TAG_W-1:0] TAG_IDLE = '0;

  localparam int unsigned UNIT_ALU = 0;
  localparam int unsigned UNIT_LSU = 1;
  localparam int unsigned UNIT_BRU = 2;
  localparam int unsigned UNIT_MUL = 3;

  typedef logic [N_UNITS-1:0] unit_vec_t;

  typedef struct packed {
    logic [TAG_W-1:0]  index;
    logic [DATA_W-1:0] result;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit <-> CDB owner signal bundle.
// The master modport is the arbiter; the slave modport is the unit side.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                      br;
  unit_vec_t                 req;
  unit_vec_t                 grnt;
  unit_vec_t                 unit_valid;
  logic [N_UNITS*TAG_W-1:0]  unit_index;
  logic [N_UNITS*DATA_W-1:0] unit_result;
  logic [TAG_W-1:0]          cdb_index;
  logic [DATA_W-1:0]         cdb_result;
  logic                      proto_err;

  modport master (
    input  br, req, unit_valid, unit_index, unit_result,
    output grnt, cdb_index, cdb_result, proto_err
  );

  modport slave (
    output br, req, unit_valid, unit_index, unit_result,
    input  grnt, cdb_index, cdb_result, proto_err
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: masked requests first; falls back to the raw
// requests when only the masked unit is asking. Returns a one-hot winner and the next pointer.
module rr_arbiter
  import cdb_arbiter_pkg::*;
(
  input  unit_vec_t        req_i,
  input  unit_vec_t        mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output unit_vec_t        gnt_o_c,
  output logic [PTR_W-1:0] ptr_nxt_o_c
);

  unit_vec_t        elig;
  unit_vec_t        cand;
  int unsigned      sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o_c     = '0;
    ptr_nxt_o_c = ptr_i;
    found       = 1'b0;
    sum         = 0;
    idx         = '0;
    elig        = req_i & ~mask_i;
    cand        = (elig != '0) ? elig : req_i;
    for (int unsigned off = 0; off < N_UNITS; off++) begin
      sum = 32'(ptr_i) + off;
      if (sum >= N_UNITS) sum = sum - N_UNITS;
      idx = PTR_W'(sum);
      if (!found && cand[idx]) begin
        found        = 1'b1;
        gnt_o_c[idx] = 1'b1;
        ptr_nxt_o_c  = (sum == N_UNITS - 1) ? '0 : PTR_W'(sum + 1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus owner: registered round-robin grant, two-cycle-delayed capture of the
// granted unit's result, single-cycle broadcast and a sticky protocol-error flag.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.master bus
);

  unit_vec_t        grnt_q, grnt_d;
  unit_vec_t        pend_q, pend_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_pkt_t         cdb_q, cdb_d;
  logic             proto_err_q, proto_err_d;

  unit_vec_t        arb_gnt_c;
  logic [PTR_W-1:0] arb_ptr_c;
  cdb_pkt_t         sel_pkt_c;
  logic             sel_valid_c;
  logic             stray_c;
  logic             multi_c;
  logic             bad_tag_c;

  // grnt_q doubles as last_gnt: a unit's req lags its own fire by one cycle
  rr_arbiter u_rr (
    .req_i       (bus.req),
    .mask_i      (grnt_q),
    .ptr_i       (rr_ptr_q),
    .gnt_o_c     (arb_gnt_c),
    .ptr_nxt_o_c (arb_ptr_c)
  );

  // Capture mux on the pended unit plus protocol checks
  always_comb begin
    sel_pkt_c = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (pend_q[i]) begin
        sel_pkt_c.index  = bus.unit_index[i*TAG_W +: TAG_W];
        sel_pkt_c.result = bus.unit_result[i*DATA_W +: DATA_W];
      end
    end
    sel_valid_c = |(bus.unit_valid & pend_q);
    stray_c     = |(bus.unit_valid & ~pend_q);
    multi_c     = !$onehot0(bus.unit_valid);
    bad_tag_c   = sel_valid_c && (sel_pkt_c.index == TAG_IDLE);
  end

  always_comb begin
    grnt_d      = grnt_q;
    pend_d      = pend_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    proto_err_d = proto_err_q;
    if (bus.br) begin
      grnt_d   = '0;
      pend_d   = '0;
      rr_ptr_d = '0;
      cdb_d    = '0;
    end else begin
      grnt_d = arb_gnt_c;
      pend_d = grnt_q;
      if (arb_gnt_c != '0) rr_ptr_d = arb_ptr_c;
      cdb_d       = (sel_valid_c && !bad_tag_c) ? sel_pkt_c : '0;
      proto_err_d = proto_err_q | stray_c | multi_c | bad_tag_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grnt_q      <= '0;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      grnt_q      <= grnt_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_q       <= cdb_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.grnt       = grnt_q;
  assign bus.cdb_index  = cdb_q.index;
  assign bus.cdb_result = cdb_q.result;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: the bench plays the functional units and keeps a per-cycle
// queue of expected broadcasts, pushed when a unit answers and popped one cycle later.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  cdb_pkt_t          cdb_q[$];
  unit_vec_t         g_saved;
  unit_vec_t         g_obs;
  unit_vec_t         req_drv;
  logic              br_drv;
  logic              respond;
  unit_vec_t         extra_uv;
  logic              zero_tag;
  logic              fix_en;
  logic [TAG_W-1:0]  fix_tag;
  logic [DATA_W-1:0] fix_data;
  logic [TAG_W-1:0]  tag_ctr;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: compare broadcast, record grant, answer the grant seen last cycle, drive inputs
  task automatic tick();
    cdb_pkt_t                  e;
    unit_vec_t                 g;
    unit_vec_t                 uv;
    logic [N_UNITS*TAG_W-1:0]  iv;
    logic [N_UNITS*DATA_W-1:0] rv;
    logic [TAG_W-1:0]          t;
    logic [DATA_W-1:0]         d;
    @(negedge clk);
    e = (cdb_q.size() != 0) ? cdb_q.pop_front() : cdb_pkt_t'('0);
    check_eq("cdb_index", 64'(bus.cdb_index), 64'(e.index));
    check_eq("cdb_result", 64'(bus.cdb_result), 64'(e.result));
    g     = bus.grnt;
    g_obs = g;
    check_eq("grnt_onehot0", 64'($onehot0(g)), 64'(1));
    uv = '0;
    iv = '0;
    rv = '0;
    e  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if ((g_saved[i] && respond) || extra_uv[i]) begin
        if (fix_en) begin
          t = fix_tag;
          d = fix_data;
        end else begin
          tag_ctr = (tag_ctr == '1) ? TAG_W'(1) : tag_ctr + TAG_W'(1);
          t = tag_ctr;
          d = DATA_W'($urandom());
        end
        if (g_saved[i] && zero_tag) t = TAG_IDLE;
        uv[i] = 1'b1;
        iv[i*TAG_W +: TAG_W]   = t;
        rv[i*DATA_W +: DATA_W] = d;
        if (g_saved[i] && !br_drv && t != TAG_IDLE) begin
          e.index  = t;
          e.result = d;
        end
      end
    end
    cdb_q.push_back(e);
    g_saved         = br_drv ? unit_vec_t'('0) : g;
    bus.unit_valid  = uv;
    bus.unit_index  = iv;
    bus.unit_result = rv;
    bus.req         = req_drv;
    bus.br          = br_drv;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.req         = '0;
    bus.br          = 1'b0;
    bus.unit_valid  = '0;
    bus.unit_index  = '0;
    bus.unit_result = '0;
    req_drv  = '0;
    br_drv   = 1'b0;
    respond  = 1'b1;
    extra_uv = '0;
    zero_tag = 1'b0;
    fix_en   = 1'b0;
    g_saved  = '0;
    cdb_q.delete();
    cdb_q.push_back(cdb_pkt_t'('0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    unit_vec_t prev;
    unit_vec_t req_last;
    n_checks = 0;
    n_fail   = 0;
    tag_ctr  = '0;
    fix_tag  = '0;
    fix_data = '0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.br   = 1'b0;
    bus.unit_valid  = '0;
    bus.unit_index  = '0;
    bus.unit_result = '0;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_grnt", 64'(bus.grnt), 64'(0));
    check_eq("rst_cdb_index", 64'(bus.cdb_index), 64'(0));
    check_eq("rst_cdb_result", 64'(bus.cdb_result), 64'(0));
    check_eq("rst_proto_err", 64'(bus.proto_err), 64'(0));

    // Single ALU request with a fixed tag/value
    do_reset();
    req_drv = unit_vec_t'(1) << UNIT_ALU;
    tick();
    req_drv = '0;
    tick();
    check_eq("t1_grnt", 64'(g_obs), 64'(4'b0001));
    fix_en   = 1'b1;
    fix_tag  = 8'h05;
    fix_data = 32'hDEADBEEF;
    tick();
    check_eq("t1_grnt_once", 64'(g_obs), 64'(0));
    fix_en = 1'b0;
    tick();
    check_eq("t1_idx", 64'(bus.cdb_index), 64'(8'h05));
    check_eq("t1_res", 64'(bus.cdb_result), 64'(32'hDEADBEEF));
    tick();
    check_eq("t1_idle", 64'(bus.cdb_index), 64'(0));

    // All four requesting: strict rotation, back-to-back broadcasts
    do_reset();
    req_drv = '1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t2_grnt", 64'(g_obs), 64'(unit_vec_t'(1) << (i % 4)));
      if (i >= 2) check_eq("t2_busy", 64'(bus.cdb_index != '0), 64'(1));
    end
    req_drv = '0;
    repeat (3) tick();

    // Sole requester re-granted every cycle; two requesters alternate
    do_reset();
    req_drv = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t3_sole", 64'(g_obs), 64'(4'b0001));
    end
    req_drv = 4'b0011;
    tick();
    prev = g_obs;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t3_alt", 64'(g_obs), (i % 2 == 0) ? 64'(4'b0010) : 64'(4'b0001));
      check_eq("t3_no_repeat", 64'((g_obs & prev) == '0), 64'(1));
      prev = g_obs;
    end
    req_drv = '0;
    repeat (3) tick();

    // Granted unit does not answer: wasted slot, no error
    do_reset();
    req_drv = unit_vec_t'(1) << UNIT_BRU;
    tick();
    req_drv = '0;
    tick();
    check_eq("t4_grnt", 64'(g_obs), 64'(4'b0100));
    respond = 1'b0;
    tick();
    respond = 1'b1;
    tick();
    check_eq("t4_idle", 64'(bus.cdb_index), 64'(0));
    check_eq("t4_err", 64'(bus.proto_err), 64'(0));

    // Extra valid from unit 2 while unit 1 is pended
    do_reset();
    req_drv = unit_vec_t'(1) << UNIT_LSU;
    tick();
    req_drv = '0;
    tick();
    check_eq("t5_grnt", 64'(g_obs), 64'(4'b0010));
    extra_uv = 4'b0100;
    tick();
    extra_uv = '0;
    check_eq("t5_err_pre", 64'(bus.proto_err), 64'(0));
    tick();
    check_eq("t5_bcast", 64'(bus.cdb_index != '0), 64'(1));
    check_eq("t5_err", 64'(bus.proto_err), 64'(1));
    repeat (3) tick();
    check_eq("t5_sticky", 64'(bus.proto_err), 64'(1));

    // Valid result carrying the idle tag is suppressed and flagged
    do_reset();
    req_drv = 4'b0001;
    tick();
    req_drv = '0;
    tick();
    zero_tag = 1'b1;
    tick();
    zero_tag = 1'b0;
    tick();
    check_eq("t5b_idx", 64'(bus.cdb_index), 64'(0));
    check_eq("t5b_err", 64'(bus.proto_err), 64'(1));

    // Valid with nothing pended is an error
    do_reset();
    tick();
    extra_uv = 4'b0001;
    tick();
    extra_uv = '0;
    tick();
    check_eq("t7_err", 64'(bus.proto_err), 64'(1));

    // Flush while unit 1 holds the grant, then resume from pointer 0
    do_reset();
    req_drv = '1;
    tick();
    tick();
    check_eq("t6_g0", 64'(g_obs), 64'(4'b0001));
    br_drv = 1'b1;
    tick();
    check_eq("t6_g1", 64'(g_obs), 64'(4'b0010));
    br_drv  = 1'b0;
    req_drv = 4'b1010;
    tick();
    check_eq("t6_flush_grnt", 64'(g_obs), 64'(0));
    check_eq("t6_flush_cdb", 64'(bus.cdb_index), 64'(0));
    req_drv = unit_vec_t'(1) << UNIT_MUL;
    tick();
    check_eq("t6_ptr0", 64'(g_obs), 64'(4'b0010));
    req_drv = '1;
    tick();
    check_eq("t6_mul", 64'(g_obs), 64'(4'b1000));
    repeat (2) tick();
    extra_uv = (g_saved == 4'b0001) ? 4'b0010 : 4'b0001;
    tick();
    extra_uv = '0;
    tick();
    check_eq("t6_err", 64'(bus.proto_err), 64'(1));
    br_drv = 1'b1;
    tick();
    br_drv = 1'b0;
    tick();
    check_eq("t6_err_kept", 64'(bus.proto_err), 64'(1));
    repeat (3) tick();
    check_eq("t6_pre_rst_busy", 64'(bus.cdb_index != '0), 64'(1));
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_grnt", 64'(bus.grnt), 64'(0));
    check_eq("t6_rst_idx", 64'(bus.cdb_index), 64'(0));
    check_eq("t6_rst_res", 64'(bus.cdb_result), 64'(0));
    check_eq("t6_rst_err", 64'(bus.proto_err), 64'(0));

    // Random requests and answers against grant rules and the scoreboard
    do_reset();
    req_last = '0;
    prev     = '0;
    for (int i = 0; i < 60; i++) begin
      req_drv = unit_vec_t'($urandom_range(0, (1 << N_UNITS) - 1));
      respond = ($urandom_range(0, 3) != 0);
      tick();
      check_eq("rnd_any", 64'(g_obs != '0), 64'(req_last != '0));
      check_eq("rnd_subset", 64'((g_obs & ~req_last) == '0), 64'(1));
      if ((g_obs & prev) != '0) check_eq("rnd_repeat_sole", 64'(req_last), 64'(prev));
      req_last = req_drv;
      prev     = g_obs;
    end
    req_drv = '0;
    respond = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
